// File: rtl/fir3_serial_mac_if.sv
// fir3_serial_mac_if
// Sample-in / result-out handshake bundle for the serial 3-tap FIR.
//   slave  : the FIR block (consumes x_in, produces y/ovf)
//   master : whoever feeds samples and drains results
interface fir3_serial_mac_if;
    // input sample channel
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_in;
    // result channel (16-bit sum + carry, matching the adder stage)
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        ovf;

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, y, ovf
    );

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/fir3_serial_mac.sv
// fir3_serial_mac
// Serial 3-tap FIR: y = C0*x[n] + C1*x[n-1] + C2*x[n-2], one shared 8x8
// multiplier accumulated over three cycles into an 18-bit register.
// A new sample is accepted only in IDLE; the result is held in DONE until
// the downstream adder stage takes it.
// Build option: `define FIR3_SATURATE_EN clamps y to 16'hFFFF whenever the
// 18-bit sum does not fit in 16 bits (ovf is raised in both builds).
module fir3_serial_mac #(
    parameter logic [7:0] C0 = 8'd1,
    parameter logic [7:0] C1 = 8'd2,
    parameter logic [7:0] C2 = 8'd1
) (
    input  logic               clk,
    input  logic               rst,
    fir3_serial_mac_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TAP0 = 3'd1,
        TAP1 = 3'd2,
        TAP2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state, state_nxt;

    // tap delay line: x0 = x[n], x1 = x[n-1], x2 = x[n-2]
    logic [7:0]  x0, x1, x2;
    logic [17:0] acc;
    logic [15:0] y_q;
    logic        ovf_q;

    logic        accept;
    logic        mac_en;
    logic        load_out;
    logic [7:0]  coef;
    logic [7:0]  tap;
    logic [15:0] prod;
    logic [17:0] acc_sum;
    logic        sum_ovf;
    logic [15:0] y_final;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state, handshake outputs and datapath strobes
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        mac_en        = 1'b0;
        load_out      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = TAP0;
                end
            end
            TAP0: begin
                mac_en    = 1'b1;
                state_nxt = TAP1;
            end
            TAP1: begin
                mac_en    = 1'b1;
                state_nxt = TAP2;
            end
            TAP2: begin
                // last product lands in acc and the output register together
                mac_en    = 1'b1;
                load_out  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pick coefficient/tap pair for the current MAC cycle
    always_comb begin
        coef = 8'd0;
        tap  = 8'd0;
        case (state)
            TAP0:    begin coef = C0; tap = x0; end
            TAP1:    begin coef = C1; tap = x1; end
            TAP2:    begin coef = C2; tap = x2; end
            default: begin coef = 8'd0; tap = 8'd0; end
        endcase
    end

    // shared multiplier and adder; 3*255*255 < 2^18 so the sum never wraps
    assign prod    = 16'(coef) * 16'(tap);
    assign acc_sum = acc + {2'b00, prod};
    assign sum_ovf = |acc_sum[17:16];

`ifdef FIR3_SATURATE_EN
    assign y_final = sum_ovf ? 16'hFFFF : acc_sum[15:0];
`else
    assign y_final = acc_sum[15:0];
`endif

    // delay line shifts only on an accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0 <= 8'd0;
            x1 <= 8'd0;
            x2 <= 8'd0;
        end else if (accept) begin
            x2 <= x1;
            x1 <= x0;
            x0 <= bus.x_in;
        end
    end

    // accumulator: cleared on accept, summed during the three tap cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc <= 18'd0;
        else if (accept) acc <= 18'd0;
        else if (mac_en) acc <= acc_sum;
    end

    // output register: loaded as DONE is entered, held until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= 16'd0;
            ovf_q <= 1'b0;
        end else if (load_out) begin
            y_q   <= y_final;
            ovf_q <= sum_ovf;
        end
    end

    assign bus.y   = y_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_fir3_serial_mac.sv
// tb_fir3_serial_mac
// Directed bench: dut_a uses default taps (1,2,1), dut_b uses (255,255,255).
// Inputs driven and outputs sampled on the falling edge.
module tb_fir3_serial_mac;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir3_serial_mac_if a_if ();
    fir3_serial_mac_if b_if ();

    fir3_serial_mac dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    fir3_serial_mac #(.C0(8'd255), .C1(8'd255), .C2(8'd255)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // present one sample from the falling edge; return at the falling edge
    // after the accepting edge
    task automatic send(input bit b, input logic [7:0] x);
        @(negedge clk);
        if (b) begin
            chk("in_ready_b", 32'(b_if.in_ready), 32'd1);
            b_if.in_valid = 1'b1;
            b_if.x_in     = x;
        end else begin
            chk("in_ready_a", 32'(a_if.in_ready), 32'd1);
            a_if.in_valid = 1'b1;
            a_if.x_in     = x;
        end
        @(posedge clk);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
    endtask

    // wait for out_valid (bounded), check latency and result
    task automatic wait_out(input bit b, input string tag, input logic [15:0] ey, input logic eo);
        int  edges;
        bit  seen;
        edges = 1;  // the accepting edge
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = b ? b_if.out_valid : a_if.out_valid;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(edges), 32'd4);
        chk({tag, "_y"}, 32'(b ? b_if.y : a_if.y), 32'(ey));
        chk({tag, "_ovf"}, 32'(b ? b_if.ovf : a_if.ovf), 32'(eo));
    endtask

    initial begin
        logic [15:0] sat1, sat2;
`ifdef FIR3_SATURATE_EN
        sat1 = 16'd65535;
        sat2 = 16'd65535;
`else
        sat1 = 16'd64514;
        sat2 = 16'd64003;
`endif
        a_if.in_valid = 1'b0; a_if.x_in = 8'd0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.x_in = 8'd0; b_if.out_ready = 1'b1;

        // power-on reset
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_y", 32'(a_if.y), 32'd0);
        chk("rst_ovf", 32'(a_if.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // default taps: 10, 20, 30 -> 10, 40, 80
        send(0, 8'd10); wait_out(0, "t2_0", 16'd10, 1'b0);
        send(0, 8'd20); wait_out(0, "t2_1", 16'd40, 1'b0);
        send(0, 8'd30); wait_out(0, "t2_2", 16'd80, 1'b0);

        // y holds outside DONE, then asynchronous reset mid-cycle
        @(negedge clk);
        chk("hold_y_idle", 32'(a_if.y), 32'd80);
        chk("hold_ov_idle", 32'(a_if.out_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_y", 32'(a_if.y), 32'd0);
        chk("arst_ovf", 32'(a_if.ovf), 32'd0);
        chk("arst_in_ready", 32'(a_if.in_ready), 32'd1);
        chk("arst_out_valid", 32'(a_if.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_y", 32'(a_if.y), 32'd0);
        chk("post_rst_in_ready", 32'(a_if.in_ready), 32'd1);

        // full-scale taps: overflow / wrap (or saturation)
        send(1, 8'd255); wait_out(1, "t3_0", 16'd65025, 1'b0);
        send(1, 8'd255); wait_out(1, "t3_1", sat1, 1'b1);
        send(1, 8'd255); wait_out(1, "t3_2", sat2, 1'b1);

        // backpressure: 5 held in DONE, 99 offered but not captured
        a_if.out_ready = 1'b0;
        send(0, 8'd5); wait_out(0, "t4_5", 16'd5, 1'b0);
        a_if.in_valid = 1'b1;
        a_if.x_in     = 8'd99;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_out_valid", 32'(a_if.out_valid), 32'd1);
            chk("bp_y", 32'(a_if.y), 32'd5);
            chk("bp_in_ready", 32'(a_if.in_ready), 32'd0);
        end
        a_if.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_idle_in_ready", 32'(a_if.in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(a_if.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        a_if.in_valid = 1'b0;
        chk("bp_acc99_in_ready", 32'(a_if.in_ready), 32'd0);
        // 99 + 2*5 + 1*0
        wait_out(0, "t4_99", 16'd109, 1'b0);

        // reset during TAP1 discards the sample and clears the line
        send(0, 8'd50);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("t5_in_ready", 32'(a_if.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("t5_no_out", 32'(a_if.out_valid), 32'd0);
        end
        send(0, 8'd7); wait_out(0, "t5_7", 16'd7, 1'b0);

        // in_valid pulsed in TAP0 and TAP2 is ignored; line is 3,7,0
        send(0, 8'd3);
        a_if.in_valid = 1'b1; a_if.x_in = 8'd200;   // TAP0
        @(posedge clk); @(negedge clk);
        a_if.in_valid = 1'b0;                       // TAP1
        @(posedge clk); @(negedge clk);
        chk("t6_in_ready_tap2", 32'(a_if.in_ready), 32'd0);
        a_if.in_valid = 1'b1;                       // TAP2
        @(posedge clk); @(negedge clk);
        a_if.in_valid = 1'b0;
        chk("t6_out_valid", 32'(a_if.out_valid), 32'd1);
        chk("t6_y", 32'(a_if.y), 32'd17);           // 3 + 2*7 + 0
        // next: 1 + 2*3 + 7 = 14
        send(0, 8'd1); wait_out(0, "t6_1", 16'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
